// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller with a 128-bit line refill/evict port.
// Optional hit/miss performance counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_ctrl #(
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_LINES        = 8,
  parameter int MEM_LATENCY      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_read,
  input  logic                        cpu_write,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [DATA_WIDTH-1:0]       cpu_wdata,
  output logic [DATA_WIDTH-1:0]       cpu_rdata,
  output logic                        cpu_stall,
  output logic                        mem_write,
  output logic [ADDR_WIDTH-3:0]       mem_addr,
  output logic [CACHE_LINE_WIDTH-1:0] mem_din,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_dout
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
`endif
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = ADDR_WIDTH - 4;
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam int MEM_AW = ADDR_WIDTH - 2;
  localparam int CNT_W  = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  logic [CACHE_LINE_WIDTH-1:0] line_q [NUM_LINES];
  logic [TAG_W-1:0]            tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]        valid_q, valid_d;
  logic [NUM_LINES-1:0]        dirty_q, dirty_d;
  logic [1:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        mem_write_q, mem_write_d;

  logic [IDX_W-1:0]            idx;
  logic [TAG_W-1:0]            req_tag;
  logic [1:0]                  wsel;
  logic [LINE_W-1:0]           req_line;
  logic [LINE_W-1:0]           victim_line;
  logic [CACHE_LINE_WIDTH-1:0] cur_line;
  logic                        req;
  logic                        hit;
  logic                        victim_dirty;
  logic                        wr_hit;
  logic                        fill;
  logic                        addr_unused;

  assign idx         = cpu_addr[4 +: IDX_W];
  assign req_tag     = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign wsel        = cpu_addr[3:2];
  assign req_line    = cpu_addr[ADDR_WIDTH-1:4];
  assign addr_unused = ^cpu_addr[1:0];

  assign cur_line     = line_q[idx];
  assign victim_line  = {tag_q[idx], idx};
  assign req          = cpu_read | cpu_write;
  assign hit          = req & valid_q[idx] & (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];

  // Reads are combinational, so a simultaneous write still returns the pre-write word.
  assign cpu_rdata = cur_line[32'(wsel)*DATA_WIDTH +: DATA_WIDTH];
  assign cpu_stall = (state_q != S_IDLE) | (req & ~hit);
  assign mem_din   = cur_line;
  assign mem_write = mem_write_q;

  always_comb begin
    mem_addr = MEM_AW'(req_line);
    if (state_q == S_WB) mem_addr = MEM_AW'(victim_line);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_hit  = 1'b0;
    fill    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            wr_hit = cpu_write;
          end else begin
            state_d = victim_dirty ? S_WB : S_ALLOC;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WB: begin
        if (cnt_q == '0) begin
          state_d = S_ALLOC;
          cnt_d   = LAT_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ALLOC: begin
        if (cnt_q == '0) begin
          fill    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = LAT_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = LAT_M1;
      end
    endcase
  end

  // The write strobe is registered so it is high exactly in the final WRITEBACK cycle.
  assign mem_write_d = (state_d == S_WB) && (cnt_d == '0);

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_hit) dirty_d[idx] = 1'b1;
    if (fill) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_write_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_write_q <= mem_write_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Line and tag storage carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_q[idx] <= mem_dout;
      tag_q[idx]  <= req_tag;
    end else if (wr_hit) begin
      line_q[idx][32'(wsel)*DATA_WIDTH +: DATA_WIDTH] <= cpu_wdata;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == S_IDLE && req) begin
      if (hit) hit_count_q  <= hit_count_q + 32'd1;
      else     miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
